// File: rtl/redmule_castin_pipe.sv
// Elastic multi-lane input cast unit: widens packed FP8/FP8ALT lanes to FP16
// (or bypasses the beat) and runs the result through PIPE_REGS handshake stages.
module redmule_castin_pipe #(
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned SRC_W     = 8,
  parameter int unsigned DST_W     = 16,
  parameter logic [2:0]  DST_FMT   = 3'd2,
  parameter int unsigned PIPE_REGS = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              cast_i,
  input  logic [2:0]        src_fmt_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] src_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] dst_o,
  output logic [4:0]        status_o,
  output logic              busy_o
);

  localparam int unsigned NUM_LANES  = DATA_W / DST_W;
  localparam logic [2:0]  FMT_FP16   = 3'd2;
  localparam logic [2:0]  FMT_FP8    = 3'd3;
  localparam logic [2:0]  FMT_FP8ALT = 3'd5;

  if (DATA_W % DST_W != 0) begin : g_err_width
    $error("DATA_W must be a multiple of DST_W");
  end
  if (PIPE_REGS > 4) begin : g_err_pipe
    $error("PIPE_REGS must be in 0..4");
  end
  if (DST_FMT != FMT_FP16 || DST_W != 16 || SRC_W != 8) begin : g_err_fmt
    $error("only FP8/FP8ALT to FP16 casting is supported");
  end

  // Returns {NV,DZ,OF,UF,NX, result}; every FP8 value is exact in FP16, so only NV can fire.
  function automatic logic [20:0] cast_lane(input logic [7:0] op, input logic [2:0] fmt);
    logic [15:0] res;
    logic        nv;
    res = '0;
    nv  = 1'b0;
    if (fmt == FMT_FP8) begin
      if (op[6:2] == 5'h1f && op[1:0] != 2'b00) begin
        res = 16'h7E00;
        nv  = !op[1];
      end else begin
        res = {op, 8'h00};
      end
    end else if (fmt == FMT_FP8ALT) begin
      if (op[6:3] == 4'hf) begin
        if (op[2:0] == 3'b000) begin
          res = {op[7], 5'h1f, 10'h000};
        end else begin
          res = 16'h7E00;
          nv  = !op[2];
        end
      end else if (op[6:3] != 4'h0) begin
        res = {op[7], 5'({1'b0, op[6:3]} + 5'd8), op[2:0], 7'h00};
      end else if (op[2]) begin
        res = {op[7], 5'd8, op[1:0], 8'h00};
      end else if (op[1]) begin
        res = {op[7], 5'd7, op[0], 9'h000};
      end else if (op[0]) begin
        res = {op[7], 5'd6, 10'h000};
      end else begin
        res = {op[7], 15'h0000};
      end
    end
    return {nv, 4'b0000, res};
  endfunction

  logic [DATA_W-1:0] cast_data;
  logic [4:0]        cast_stat;
  logic [DATA_W-1:0] in_data;
  logic [4:0]        in_stat;
  logic [20:0]       lane_res;

  always_comb begin
    cast_data = '0;
    cast_stat = '0;
    lane_res  = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      lane_res = cast_lane(src_i[i*SRC_W +: SRC_W], src_fmt_i);
      cast_data[i*DST_W +: DST_W] = lane_res[15:0];
      cast_stat = cast_stat | lane_res[20:16];
    end
    in_data = cast_i ? cast_data : src_i;
    in_stat = cast_i ? cast_stat : 5'b00000;
  end

  logic [4:0] out_stat;

  if (PIPE_REGS == 0) begin : g_comb
    // Output valid is gated by clear so downstream never sees a beat upstream was refused.
    assign in_ready_o  = out_ready_i & ~clear_i;
    assign out_valid_o = in_valid_i & ~clear_i;
    assign dst_o       = in_data;
    assign out_stat    = in_stat;
    assign busy_o      = 1'b0;
  end else begin : g_pipe
    logic [PIPE_REGS-1:0] vld_q;
    logic [DATA_W-1:0]    dat_q [PIPE_REGS];
    logic [4:0]           st_q  [PIPE_REGS];
    logic [PIPE_REGS-1:0] rdy;
    logic [PIPE_REGS:0]   ch_vld;
    logic [DATA_W-1:0]    ch_dat [PIPE_REGS+1];
    logic [4:0]           ch_st  [PIPE_REGS+1];

    assign ch_vld = {vld_q, in_valid_i};

    // Ready chain in closed form: stage k can move if the sink is ready or any stage from k on is empty.
    always_comb begin
      ch_dat[0] = in_data;
      ch_st[0]  = in_stat;
      for (int unsigned k = 0; k < PIPE_REGS; k++) begin
        ch_dat[k+1] = dat_q[k];
        ch_st[k+1]  = st_q[k];
        rdy[k]      = out_ready_i;
        for (int unsigned j = k; j < PIPE_REGS; j++) begin
          rdy[k] = rdy[k] | ~vld_q[j];
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= '0;
        for (int unsigned k = 0; k < PIPE_REGS; k++) begin
          dat_q[k] <= '0;
          st_q[k]  <= '0;
        end
      end else if (clear_i) begin
        vld_q <= '0;
      end else begin
        for (int unsigned k = 0; k < PIPE_REGS; k++) begin
          if (rdy[k]) begin
            vld_q[k] <= ch_vld[k];
            if (ch_vld[k]) begin
              dat_q[k] <= ch_dat[k];
              st_q[k]  <= ch_st[k];
            end
          end
        end
      end
    end

    assign in_ready_o  = rdy[0] & ~clear_i;
    assign out_valid_o = vld_q[PIPE_REGS-1];
    assign dst_o       = dat_q[PIPE_REGS-1];
    assign out_stat    = st_q[PIPE_REGS-1];
    assign busy_o      = |vld_q;
  end

  logic [4:0] status_q;
  logic [4:0] status_d;

  always_comb begin
    status_d = status_q;
    if (clear_i) begin
      status_d = '0;
    end else if (out_valid_o && out_ready_i) begin
      status_d = status_q | out_stat;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  assign status_o = status_q;

endmodule

// File: tb/tb_redmule_castin_pipe.sv
// Scoreboard bench for redmule_castin_pipe: real-valued FP8 -> FP16 reference,
// driver pushes expected beats on accept, monitor pops on each output handshake.
module tb_redmule_castin_pipe;

  localparam logic [2:0] FP8    = 3'd3;
  localparam logic [2:0] FP8ALT = 3'd5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         cast = 1'b0;
  logic [2:0]   fmt = FP8;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] src = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [255:0] dst;
  logic [4:0]   status;
  logic         busy;

  logic         clr0 = 1'b0;
  logic         c0 = 1'b0;
  logic [2:0]   f0 = FP8;
  logic         iv0 = 1'b0;
  logic         ir0;
  logic [63:0]  s0 = '0;
  logic         ov0;
  logic         or0 = 1'b0;
  logic [63:0]  d0;
  logic [4:0]   st0;
  logic         busy0;

  always #5 clk = ~clk;

  redmule_castin_pipe #(.DATA_W(256), .SRC_W(8), .DST_W(16), .PIPE_REGS(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .cast_i(cast), .src_fmt_i(fmt),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .src_i(src),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .dst_o(dst),
    .status_o(status), .busy_o(busy)
  );

  redmule_castin_pipe #(.DATA_W(64), .SRC_W(8), .DST_W(16), .PIPE_REGS(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr0), .cast_i(c0), .src_fmt_i(f0),
    .in_valid_i(iv0), .in_ready_o(ir0), .src_i(s0),
    .out_valid_o(ov0), .out_ready_i(or0), .dst_o(d0),
    .status_o(st0), .busy_o(busy0)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int pat = 0;
  int rdy_mode = 0;
  bit mon_en = 1'b0;
  bit blocked = 1'b0;

  typedef struct {
    logic [255:0] d;
    logic [4:0]   st;
    bit           lat;
    int           cyc;
  } exp_t;
  exp_t sbq[$];

  logic [4:0]   exp_status = '0;
  bit           prev_stall = 1'b0;
  logic [255:0] prev_dst = '0;

  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endfunction

  function automatic real pow2(input int x);
    real r;
    r = 1.0;
    if (x >= 0) for (int i = 0; i < x; i++) r = r * 2.0;
    else for (int i = 0; i < -x; i++) r = r / 2.0;
    return r;
  endfunction

  // Decode the FP8 value to a real number, then re-encode that number as FP16.
  function automatic void ref_cast(input logic [7:0] b, input logic [2:0] f,
                                   output logic [15:0] r, output logic nv);
    int eb, mb, bias, bi, e, m, ex;
    real v;
    logic s;
    eb   = (f == FP8) ? 5 : 4;
    mb   = 7 - eb;
    bias = (1 << (eb - 1)) - 1;
    bi   = int'(b);
    s    = b[7];
    e    = (bi >> mb) & ((1 << eb) - 1);
    m    = bi & ((1 << mb) - 1);
    nv   = 1'b0;
    r    = '0;
    if (e == (1 << eb) - 1) begin
      if (m == 0) r = s ? 16'hFC00 : 16'h7C00;
      else begin
        r  = 16'h7E00;
        nv = ((m >> (mb - 1)) & 1) == 0;
      end
      return;
    end
    if (e == 0) v = real'(m) * pow2(1 - bias - mb);
    else v = real'(m + (1 << mb)) * pow2(e - bias - mb);
    if (v == 0.0) begin
      r = {s, 15'h0000};
      return;
    end
    ex = -30;
    while (pow2(ex + 1) <= v) ex++;
    if (ex >= -14) r = {s, 5'(ex + 15), 10'($rtoi((v / pow2(ex) - 1.0) * 1024.0))};
    else r = {s, 5'd0, 10'($rtoi(v / pow2(-24)))};
  endfunction

  function automatic void ref_beat(input logic [255:0] sv, input logic c, input logic [2:0] f,
                                   input int nl, output logic [255:0] d, output logic [4:0] st);
    logic [15:0] r;
    logic        nv;
    logic [7:0]  b;
    d  = '0;
    st = '0;
    if (!c) begin
      d = sv;
      return;
    end
    for (int i = 0; i < nl; i++) begin
      b = sv[i*8 +: 8];
      ref_cast(b, f, r, nv);
      d[i*16 +: 16] = r;
      if (nv) st[4] = 1'b1;
    end
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = (pat % 4 == 0) || (pat % 4 == 3);
        pat++;
      end
      2: out_ready = ($urandom % 4) != 0;
      default: out_ready = 1'b0;
    endcase
  end

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready && cast)
      assert (fmt == FP8 || fmt == FP8ALT) else $error("unsupported src_fmt_i accepted");
  end

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("status", status, exp_status);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", dst, prev_dst);
      end
      if (clear) begin
        sbq.delete();
        exp_status = '0;
        prev_stall = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_beat: got %0h, expected no beat", dst);
          end else begin
            e = sbq.pop_front();
            chk("dst", dst, e.d);
            if (e.lat) chk("latency", cyc - e.cyc, 2);
            exp_status = exp_status | e.st;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_dst   = dst;
      end
    end
  end

  task automatic send(input logic c, input logic [2:0] f, input logic [255:0] data, input bit lat);
    int n;
    bit done;
    logic [255:0] d;
    logic [4:0] st;
    n    = 0;
    done = 1'b0;
    in_valid = 1'b1;
    cast = c;
    fmt  = f;
    src  = data;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        ref_beat(data, c, f, 16, d, st);
        sbq.push_back('{d, st, lat, cyc});
        done = 1'b1;
      end else begin
        blocked = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout: got no accept, expected accept within 200 cycles");
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_cycle(input logic with_beat);
    clear    = 1'b1;
    in_valid = with_beat;
    cast     = 1'b1;
    fmt      = FP8;
    src      = {8{$urandom}};
    @(negedge clk);
    chk("clear_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", sbq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] d;
    logic [4:0]   st;
    logic         c;
    logic [2:0]   f;
    logic [4:0]   exp0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dst", dst, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_status", status, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // plain FP8 cast, upper unused half is garbage
    send(1'b1, FP8, {$urandom, $urandom, $urandom, $urandom, {16{8'h3C}}}, 1'b1);
    idle(4);

    // format changes beat to beat
    send(1'b1, FP8ALT, {224'h0, 16'h0000, 16'hB838}, 1'b1);
    send(1'b1, FP8, {16{16'hC0C0}}, 1'b1);
    idle(4);

    // sticky NV until clear
    send(1'b1, FP8, {248'h0, 8'h7D}, 1'b1);
    repeat (3) send(1'b1, FP8, {16{16'h3C3C}}, 1'b1);
    idle(4);
    chk("nv_sticky", status[4], 1);
    clear_cycle(1'b1);
    idle(3);
    chk("status_cleared", status, 0);

    // bypass interleaved with cast
    for (int i = 0; i < 4; i++) begin
      send(1'b1, FP8ALT, {8{$urandom}}, 1'b1);
      send(1'b0, FP8, {8{32'hDEADBEEF}}, 1'b1);
    end
    idle(4);

    // backpressure 1,0,0,1,...
    pat = 0;
    rdy_mode = 1;
    blocked = 1'b0;
    for (int i = 0; i < 6; i++) send(1'b1, (i % 2) ? FP8ALT : FP8, {8{$urandom}}, 1'b0);
    chk("in_ready_dropped", blocked, 1);
    drain();

    // random mixed traffic with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      c = ($urandom % 4) != 0;
      f = ($urandom % 2) ? FP8 : FP8ALT;
      send(c, f, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0);
      if ($urandom % 3 == 0) idle($urandom % 3);
    end
    rdy_mode = 0;
    drain();

    // clear with two beats in flight
    send(1'b1, FP8ALT, {248'h0, 8'h7B}, 1'b0);
    idle(4);
    chk("nv_before_clear", status, 5'b10000);
    rdy_mode = 3;
    idle(2);
    send(1'b1, FP8, {8{$urandom}}, 1'b0);
    send(1'b0, FP8, {8{$urandom}}, 1'b0);
    chk("busy_in_flight", busy, 1);
    clear_cycle(1'b1);
    @(negedge clk);
    chk("clr_busy", busy, 0);
    chk("clr_out_valid", out_valid, 0);
    chk("clr_status", status, 0);
    @(posedge clk);
    #1;
    rdy_mode = 0;
    idle(6);
    drain();

    // combinational variant
    exp0 = '0;
    for (int i = 0; i < 24; i++) begin
      if (i == 0) begin
        iv0 = 1'b1; or0 = 1'b1; c0 = 1'b1; f0 = FP8; s0 = 64'h7D;
      end else begin
        iv0 = $urandom % 2;
        or0 = $urandom % 2;
        c0  = ($urandom % 4) != 0;
        f0  = ($urandom % 2) ? FP8 : FP8ALT;
        s0  = {$urandom, $urandom};
      end
      @(negedge clk);
      ref_beat({192'h0, s0}, c0, f0, 4, d, st);
      chk("p0_in_ready", ir0, or0);
      chk("p0_out_valid", ov0, iv0);
      chk("p0_dst", d0, d[63:0]);
      chk("p0_status", st0, exp0);
      chk("p0_busy", busy0, 0);
      if (iv0 && or0) exp0 = exp0 | st;
      @(posedge clk);
      #1;
    end
    iv0 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
